// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multicycle multiply/divide unit with architectural HI/LO and D-stage stall.
module md_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        done
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sh_q, sh_d, sl_q, sl_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic        accept;
  logic        is_muldiv;
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign is_muldiv = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_DIV) | (op == OP_DIVU);
  assign accept    = start & ~flush & (state_q == S_IDLE) & (op != 3'b110) & (op != 3'b111);

  assign prod = (op == OP_MULT) ? ({{32{A[31]}}, A} * {{32{B[31]}}, B})
                                : ({32'b0, A} * {32'b0, B});

  // Sign-magnitude division keeps 0x80000000 / -1 well defined and truncates toward zero.
  always_comb begin
    a_neg  = (op == OP_DIV) & A[31];
    b_neg  = (op == OP_DIV) & B[31];
    a_mag  = a_neg ? (~A + 32'd1) : A;
    b_mag  = b_neg ? (~B + 32'd1) : B;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sl_d    = sl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {sh_d, sl_d} = prod;
              cnt_d        = CNT_W'(MULT_CYC);
              state_d      = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor shadows the current HI/LO so commit leaves them intact.
              sh_d    = (B == 32'd0) ? hi_q : rem;
              sl_d    = (B == 32'd0) ? lo_q : quot;
              cnt_d   = CNT_W'(DIV_CYC);
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = sh_q;
          lo_d    = sl_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      sl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = d_uses_md & (busy | (start & ~flush & is_muldiv));
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign done  = done_q;

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYC, default 10, busy duration in cycles for div/divu.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 start  in  1  E-stage instruction is a multiply/divide-unit operation this cycle.
REQ-006 op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
REQ-007 A  in  32  operand rs (dividend, multiplicand, mthi/mtlo source).
REQ-008 B  in  32  operand rt (divisor, multiplier).
REQ-009 flush  in  1  exception/interrupt cancels the E-stage instruction this cycle.
REQ-010 d_uses_md  in  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo.
REQ-011 busy  out  1  operation in progress.
REQ-012 stall  out  1  D-stage freeze request to the hazard unit.
REQ-013 HI  out  32  architectural HI register.
REQ-014 LO  out  32  architectural LO register.
REQ-015 done  out  1  one-cycle pulse on the edge HI/LO are committed by mult/div.

Function
REQ-016 States: IDLE, MUL, DIV; a down-counter cnt tracks remaining cycles.
REQ-017 Accept = start & !flush & state==IDLE & op not reserved.
REQ-018 Accept with mult/multu: compute 64-bit product into shadow {sh,sl}; cnt<=MULT_CYC; state<=MUL.
REQ-019 Accept with div/divu: shadow sl<=quotient, sh<=remainder; cnt<=DIV_CYC; state<=DIV.
REQ-020 mult/div signed: two's complement; quotient truncates toward zero; remainder takes dividend's sign.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-022 Divide by zero: full DIV_CYC busy; HI/LO retain prior values at commit; done still pulses.
REQ-023 In MUL/DIV: cnt decrements each edge; on the edge where cnt==1, HI<=sh, LO<=sl, done<=1, state<=IDLE.
REQ-024 busy = (state!=IDLE), registered; high exactly MULT_CYC/DIV_CYC cycles after the accept edge.
REQ-025 Accept with mthi: HI<=A on the next edge; LO unchanged; no busy, no done.
REQ-026 Accept with mtlo: LO<=A on the next edge; HI unchanged; no busy, no done.
REQ-027 start while busy: ignored (hazard unit guarantees it never occurs; no state change).
REQ-028 start & flush together: ignored; HI/LO/state unchanged.
REQ-029 flush while busy: no effect; in-flight operation completes and commits.
REQ-030 Reserved op with start: ignored.
REQ-031 stall = d_uses_md & (busy | (start & !flush & op in {mult,multu,div,divu})), combinational.
REQ-032 HI/LO readers receive the committed value the cycle after done; no bypass of shadow values.

Reset
REQ-033 reset low: state=IDLE, cnt=0, HI=0, LO=0, shadow=0, busy=0, done=0, stall low except by combinational term.
REQ-034 reset asserted mid-operation aborts it; HI/LO read 0, no done pulse after release.
REQ-035 First accept is possible on the first rising edge after reset deasserts.

Verification
REQ-036 mult A=0xFFFFFFFF B=2 -> busy 5 cycles, done pulse, HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-037 div A=-7 (0xFFFFFFF9) B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3 HI=1.
REQ-038 divu A=5 B=0 after HI=0x11, LO=0x22 -> busy 10 cycles, done pulses, HI=0x11 LO=0x22 unchanged.
REQ-039 mthi A=0xDEADBEEF then mtlo A=0x12345678 -> HI=0xDEADBEEF, LO=0x12345678 after two edges, busy never high.
REQ-040 start div with flush=1 -> busy stays 0, HI/LO unchanged; flush pulse during MUL -> result still commits at cycle 5.
REQ-041 d_uses_md=1 throughout mult accept -> stall high accept cycle plus 5 busy cycles, low after; reset low at busy cycle 3 -> busy=0, HI=LO=0 immediately.
